button_conditioner: RTL and testbench

Front-end input block that turns raw, bouncy, asynchronous push-button levels into the single-`mclk` `vButton` pulses and the `clk_mode` selector consumed by the clock top-level. It sits between the board pins and the time-keeping core. It provides:

- synchronisation and debounce on every button;
- single-cycle press pulses;
- auto-repeat on the digit buttons;
- mode cycling and long-press escape on a dedicated mode button.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/button_conditioner_if.sv | 25 ++
 rtl/btn_channel.sv | 118 +++++++++++
 rtl/button_conditioner.sv | 88 ++++++++
 tb/tb_button_conditioner.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock front end: mode encodings, button
// indices, press-FSM states and the mode-cycling helper.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_DEFAULT   = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2,
        MODE_SET_DATE  = 2'd3
    } clk_mode_e;

    localparam int BTN_UNITS = 0;
    localparam int BTN_TENS  = 1;
    localparam int BTN_3     = 2;
    localparam int BTN_AMPM  = 3;
    localparam int NUM_BTNS  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } press_state_e;

    // Next mode on a short press of the mode button, wrapping 3 -> 0.
    function automatic clk_mode_e next_mode(input clk_mode_e m);
        return clk_mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Board-side bundle between the button pins and the clock top level.
// master: the pins / consumer side; slave: the conditioner itself.
interface button_conditioner_if;
    import clock_pkg::*;

    logic [NUM_BTNS-1:0] pButton;
    logic                mode_btn;
    logic [NUM_BTNS-1:0] vButton;
    logic [1:0]          clk_mode;

    modport master (
        output pButton,
        output mode_btn,
        input  vButton,
        input  clk_mode
    );

    modport slave (
        input  pButton,
        input  mode_btn,
        output vButton,
        output clk_mode
    );

endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter and the
// IDLE/HELD/REPEAT press FSM producing press and hold/repeat pulses.
// The pulses are registered on the same edge that accepts the new level,
// so the top level can register its outputs one edge later.
module btn_channel
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int HOLD_CYCLES     = 10000000,
    parameter int REPEAT_CYCLES   = 4000000,
    parameter bit HOLD_EN         = 1'b1,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic mclk,
    input  logic rst,
    input  logic raw,
    output logic press_pulse,
    output logic hold_pulse
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [1:0]       sync;
    logic             stable;
    logic [DB_W-1:0]  db_cnt;
    logic [HLD_W-1:0] hold_cnt;
    logic [REP_W-1:0] rep_cnt;
    press_state_e     state;

    logic accept;
    logic rise;
    logic fall;

    // The counter only ever runs while the synchronised level disagrees
    // with stable, so reaching DB_LAST here is the D-th mismatch.
    assign accept = (sync[1] != stable) && (db_cnt >= DB_LAST);
    assign rise   = accept &&  sync[1];
    assign fall   = accept && !sync[1];

    // Synchronise the raw level and debounce it into stable.
    always_ff @(posedge mclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values; blocking here would collapse the
        // two synchroniser stages into one.
        if (rst) begin
            sync   <= 2'b00;
            stable <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == stable) begin
                db_cnt <= '0;
            end else if (db_cnt >= DB_LAST) begin
                stable <= sync[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Press FSM: press pulse on accepted rise, hold then periodic repeats.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state       <= IDLE;
            press_pulse <= 1'b0;
            hold_pulse  <= 1'b0;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
        end else begin
            press_pulse <= 1'b0;
            hold_pulse  <= 1'b0;
            if (fall) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            press_pulse <= 1'b1;
                            hold_cnt    <= '0;
                            state       <= HELD;
                        end
                    end
                    HELD: begin
                        // Without hold support the channel just waits for release.
                        if (HOLD_EN) begin
                            if (hold_cnt >= HLD_LAST) begin
                                hold_pulse <= 1'b1;
                                rep_cnt    <= '0;
                                state      <= REPEAT;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (REPEAT_EN) begin
                            if (rep_cnt >= REP_LAST) begin
                                hold_pulse <= 1'b1;
                                rep_cnt    <= '0;
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Button front end: five conditioned channels, the clk_mode register and
// the masking that suppresses digit pulses while the mode is changing.
module button_conditioner
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int HOLD_CYCLES     = 10000000,
    parameter int REPEAT_CYCLES   = 4000000
) (
    input  logic               mclk,
    input  logic               rst,
    button_conditioner_if.slave bus
);

    logic [NUM_BTNS-1:0] btn_press;
    logic [NUM_BTNS-1:0] btn_hold;
    logic [NUM_BTNS-1:0] btn_pulse;
    logic                mode_press;
    logic                mode_hold;

    clk_mode_e           clk_mode_q;
    clk_mode_e           mode_next;
    logic                mode_change;
    logic [NUM_BTNS-1:0] vbutton_q;

    // Digit buttons auto-repeat; setampm only ever produces its press pulse.
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .HOLD_EN         (i != BTN_AMPM),
            .REPEAT_EN       (i != BTN_AMPM)
        ) u_chan (
            .mclk        (mclk),
            .rst         (rst),
            .raw         (bus.pButton[i]),
            .press_pulse (btn_press[i]),
            .hold_pulse  (btn_hold[i])
        );
    end

    // Mode button: long press escapes to default once, never repeats.
    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .HOLD_EN         (1'b1),
        .REPEAT_EN       (1'b0)
    ) u_mode (
        .mclk        (mclk),
        .rst         (rst),
        .raw         (bus.mode_btn),
        .press_pulse (mode_press),
        .hold_pulse  (mode_hold)
    );

    assign btn_pulse = btn_press | btn_hold;

    // Next mode and whether this edge actually changes it.
    always_comb begin
        // NOTE: default first so every path assigns mode_next; a missing
        // else would infer a latch.
        mode_next = clk_mode_q;
        if (mode_hold) begin
            mode_next = MODE_DEFAULT;
        end else if (mode_press) begin
            mode_next = next_mode(clk_mode_q);
        end
        mode_change = (mode_next != clk_mode_q);
    end

    // Register mode and pulses together; digit pulses drop on a mode change.
    always_ff @(posedge mclk) begin
        if (rst) begin
            clk_mode_q <= MODE_DEFAULT;
            vbutton_q  <= '0;
        end else begin
            clk_mode_q <= mode_next;
            vbutton_q  <= {btn_pulse[BTN_AMPM],
                           btn_pulse[BTN_3:BTN_UNITS] & ~{3{mode_change}}};
        end
    end

    assign bus.vButton  = vbutton_q;
    assign bus.clk_mode = clk_mode_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with D=4, H=20, R=8.
// A behavioural model predicts vButton/clk_mode every cycle from the raw
// input history; directed tasks also check the documented pulse cycles.
module tb_button_conditioner;
    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;

    logic mclk;
    logic rst;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .mclk (mclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    // Per channel (0..3 pButton, 4 mode_btn): a 2-sample delay line for the
    // synchroniser, a window of the last D synchronised samples, the
    // accepted level and the edge at which the current press was accepted.
    bit         dly0 [5];
    bit         dly1 [5];
    bit [D-1:0] win  [5];
    int         nsamp[5];
    bit         stab [5];
    int         rise_at[5];
    int         edge_no = 0;

    logic [3:0] exp_vb   = '0;
    logic [1:0] exp_mode = '0;
    logic [3:0] nxt_vb   = '0;
    logic [1:0] nxt_mode = '0;

    task automatic model_edge(input logic [4:0] raw, input logic rv);
        bit [4:0]   press;
        bit [4:0]   hold;
        bit         s;
        int         age;
        logic [1:0] new_mode;
        bit         chg;
        if (rv) begin
            for (int c = 0; c < 5; c++) begin
                dly0[c] = 0; dly1[c] = 0; win[c] = '0;
                nsamp[c] = 0; stab[c] = 0; rise_at[c] = 0;
            end
            exp_vb = '0; exp_mode = '0; nxt_vb = '0; nxt_mode = '0;
            return;
        end
        exp_vb   = nxt_vb;
        exp_mode = nxt_mode;
        press = '0;
        hold  = '0;
        for (int c = 0; c < 5; c++) begin
            s       = dly1[c];
            dly1[c] = dly0[c];
            dly0[c] = raw[c];
            win[c]  = {win[c][D-2:0], s};
            nsamp[c]++;
            if (nsamp[c] >= D && win[c] == {D{~stab[c]}}) begin
                stab[c] = ~stab[c];
                if (stab[c]) begin
                    rise_at[c] = edge_no;
                    press[c]   = 1'b1;
                end
            end else if (stab[c]) begin
                age = edge_no - rise_at[c];
                if (c < 3)
                    hold[c] = (age == H) || (age > H && (age - H) % R == 0);
                else if (c == 4)
                    hold[c] = (age == H);
            end
        end
        new_mode = exp_mode;
        if (hold[4])       new_mode = 2'd0;
        else if (press[4]) new_mode = exp_mode + 2'd1;
        chg      = (new_mode != exp_mode);
        nxt_mode = new_mode;
        nxt_vb[3] = press[3];
        for (int b = 0; b < 3; b++) nxt_vb[b] = (press[b] | hold[b]) & ~chg;
    endtask

    // Drive one cycle of inputs, advance the model on the edge, return at negedge.
    task automatic step(input logic [3:0] pbv, input logic mbv, input logic rv);
        bus.pButton  = pbv;
        bus.mode_btn = mbv;
        rst          = rv;
        @(posedge mclk);
        edge_no++;
        model_edge({mbv, pbv}, rv);
        @(negedge mclk);
    endtask

    task automatic quiet_reset();
        step(4'b0, 1'b0, 1'b1);
        step(4'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0, 1'b0, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        vectors++;
        if (bus.vButton !== 4'b0 || bus.clk_mode !== 2'd0) begin
            miscompares++;
            $display("FAIL reset: vButton=%b clk_mode=%0d, expected 0000 0", bus.vButton, bus.clk_mode);
        end
        for (int i = 0; i < 4; i++) step(4'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clean_press();
        int n = 0;
        int at = -1;
        quiet_reset();
        for (int i = 1; i <= 25; i++) begin
            step((i <= 10) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
            vectors++;
            if (bus.vButton !== exp_vb || bus.clk_mode !== exp_mode) begin
                miscompares++;
                $display("FAIL clean_press cyc %0d: vButton=%b mode=%0d, expected %b %0d", i, bus.vButton, bus.clk_mode, exp_vb, exp_mode);
            end
            if (bus.vButton[0]) begin n++; at = i; end
        end
        vectors++;
        if (n != 1 || at != 7) begin
            miscompares++;
            $display("FAIL clean_press_timing: %0d pulses, last at %0d, expected 1 at 7", n, at);
        end
    endtask

    task automatic test_bounce();
        int n = 0;
        int at = -1;
        logic lvl;
        quiet_reset();
        for (int i = 1; i <= 37; i++) begin
            if (i <= 12)      lvl = (((i - 1) / 2) % 2) == 0;
            else if (i <= 22) lvl = 1'b1;
            else              lvl = 1'b0;
            step({2'b00, lvl, 1'b0}, 1'b0, 1'b0);
            vectors++;
            if (bus.vButton !== exp_vb || bus.clk_mode !== exp_mode) begin
                miscompares++;
                $display("FAIL bounce cyc %0d: vButton=%b mode=%0d, expected %b %0d", i, bus.vButton, bus.clk_mode, exp_vb, exp_mode);
            end
            if (bus.vButton[1]) begin n++; at = i; end
        end
        vectors++;
        if (n != 1 || at != 19) begin
            miscompares++;
            $display("FAIL bounce_timing: %0d pulses, last at %0d, expected 1 at 19", n, at);
        end
    endtask

    task automatic test_repeat();
        int got[$];
        int want[6] = '{7, 27, 35, 43, 51, 59};
        quiet_reset();
        for (int i = 1; i <= 75; i++) begin
            step((i <= 55) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
            vectors++;
            if (bus.vButton !== exp_vb || bus.clk_mode !== exp_mode) begin
                miscompares++;
                $display("FAIL repeat cyc %0d: vButton=%b mode=%0d, expected %b %0d", i, bus.vButton, bus.clk_mode, exp_vb, exp_mode);
            end
            if (bus.vButton[2]) got.push_back(i);
        end
        vectors++;
        if (got.size() != 6) begin
            miscompares++;
            $display("FAIL repeat_count: %0d pulses, expected 6", got.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                vectors++;
                if (got[k] != want[k]) begin
                    miscompares++;
                    $display("FAIL repeat_pulse%0d: at %0d, expected %0d", k, got[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_ampm();
        int n = 0;
        int at = -1;
        quiet_reset();
        for (int i = 1; i <= 70; i++) begin
            step((i <= 55) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
            vectors++;
            if (bus.vButton !== exp_vb || bus.clk_mode !== exp_mode) begin
                miscompares++;
                $display("FAIL ampm cyc %0d: vButton=%b mode=%0d, expected %b %0d", i, bus.vButton, bus.clk_mode, exp_vb, exp_mode);
            end
            if (bus.vButton[3]) begin n++; at = i; end
        end
        vectors++;
        if (n != 1 || at != 7) begin
            miscompares++;
            $display("FAIL ampm_timing: %0d pulses, last at %0d, expected 1 at 7", n, at);
        end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] want[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        quiet_reset();
        for (int p = 0; p < 4; p++) begin
            for (int i = 1; i <= 20; i++) begin
                step(4'b0, (i <= 10), 1'b0);
                vectors++;
                if (bus.vButton !== exp_vb || bus.clk_mode !== exp_mode) begin
                    miscompares++;
                    $display("FAIL mode_cycle p%0d cyc %0d: vButton=%b mode=%0d, expected %b %0d", p, i, bus.vButton, bus.clk_mode, exp_vb, exp_mode);
                end
            end
            vectors++;
            if (bus.clk_mode !== want[p]) begin
                miscompares++;
                $display("FAIL mode_cycle_value%0d: clk_mode=%0d, expected %0d", p, bus.clk_mode, want[p]);
            end
        end
    endtask

    task automatic test_mode_hold();
        quiet_reset();
        for (int i = 1; i <= 40; i++) step(4'b0, (i <= 10) || (i > 20 && i <= 30), 1'b0);
        vectors++;
        if (bus.clk_mode !== 2'd2) begin
            miscompares++;
            $display("FAIL mode_hold_setup: clk_mode=%0d, expected 2", bus.clk_mode);
        end
        for (int i = 1; i <= 45; i++) begin
            step(4'b0, (i <= 30), 1'b0);
            vectors++;
            if (bus.vButton !== exp_vb || bus.clk_mode !== exp_mode) begin
                miscompares++;
                $display("FAIL mode_hold cyc %0d: vButton=%b mode=%0d, expected %b %0d", i, bus.vButton, bus.clk_mode, exp_vb, exp_mode);
            end
            if (i == 7 || i == 27) begin
                vectors++;
                if (bus.clk_mode !== ((i == 7) ? 2'd3 : 2'd0)) begin
                    miscompares++;
                    $display("FAIL mode_hold_at%0d: clk_mode=%0d, expected %0d", i, bus.clk_mode, (i == 7) ? 3 : 0);
                end
            end
        end
    endtask

    task automatic test_mask();
        quiet_reset();
        for (int i = 1; i <= 25; i++) begin
            step((i <= 10) ? 4'b0001 : 4'b0000, (i <= 10), 1'b0);
            vectors++;
            if (bus.vButton !== exp_vb || bus.clk_mode !== exp_mode) begin
                miscompares++;
                $display("FAIL mask cyc %0d: vButton=%b mode=%0d, expected %b %0d", i, bus.vButton, bus.clk_mode, exp_vb, exp_mode);
            end
            if (i == 7) begin
                vectors++;
                if (bus.vButton[0] !== 1'b0 || bus.clk_mode !== 2'd1) begin
                    miscompares++;
                    $display("FAIL mask_coincident: vButton[0]=%b clk_mode=%0d, expected 0 1", bus.vButton[0], bus.clk_mode);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int n = 0;
        int at = -1;
        quiet_reset();
        for (int i = 1; i <= 40; i++) step(4'b0, (i <= 10) || (i > 20 && i <= 30), 1'b0);
        for (int i = 1; i <= 60; i++) begin
            step((i <= 45) ? 4'b0001 : 4'b0000, 1'b0, (i == 30));
            vectors++;
            if (bus.vButton !== exp_vb || bus.clk_mode !== exp_mode) begin
                miscompares++;
                $display("FAIL reset_hold cyc %0d: vButton=%b mode=%0d, expected %b %0d", i, bus.vButton, bus.clk_mode, exp_vb, exp_mode);
            end
            if (i == 29 || i == 30) begin
                vectors++;
                if (bus.clk_mode !== ((i == 29) ? 2'd2 : 2'd0) || (i == 30 && bus.vButton !== 4'b0)) begin
                    miscompares++;
                    $display("FAIL reset_hold_at%0d: vButton=%b clk_mode=%0d", i, bus.vButton, bus.clk_mode);
                end
            end
            if (i > 30 && bus.vButton[0]) begin n++; at = i; end
        end
        vectors++;
        if (n != 1 || at != 37) begin
            miscompares++;
            $display("FAIL reset_hold_repress: %0d pulses, last at %0d, expected 1 at 37", n, at);
        end
    endtask

    task automatic test_random(input int cycles, input int flip_range);
        logic [3:0] pbv = '0;
        logic       mbv = 1'b0;
        logic       rv;
        for (int i = 0; i < cycles; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, flip_range) == 0) pbv[b] = ~pbv[b];
            if ($urandom_range(0, flip_range) == 0) mbv = ~mbv;
            rv = ($urandom_range(0, 799) == 0);
            step(pbv, mbv, rv);
            vectors++;
            if (bus.vButton !== exp_vb || bus.clk_mode !== exp_mode) begin
                miscompares++;
                $display("FAIL random cyc %0d: vButton=%b mode=%0d, expected %b %0d", i, bus.vButton, bus.clk_mode, exp_vb, exp_mode);
            end
        end
    endtask

    initial begin
        bus.pButton  = '0;
        bus.mode_btn = 1'b0;
        rst          = 1'b1;
        @(negedge mclk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_ampm();
        test_mode_cycle();
        test_mode_hold();
        test_mask();
        test_reset_mid_hold();
        quiet_reset();
        test_random(2000, 12);
        test_random(3000, 60);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
